// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types for the fetch stage
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH      = 2'd0,
        REDIR_PEND = 2'd1,
        HALTED     = 2'd2
    } fetch_state_t;

    localparam word_t PC_STEP = 32'd4;

    // Branch/jump targets are forced onto a word boundary.
    function automatic word_t align_word(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_latch.sv
// rtl/if_id_latch.sv - IF/ID pipeline register with flush > wen priority and freeze
module if_id_latch
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        freeze,
    input  logic        flush,
    input  logic        wen,
    input  logic        fetch_ok,
    input  logic        ihit,
    input  logic [31:0] fetch_instr,
    input  logic [31:0] fetch_npc,
    output logic [31:0] instr,
    output logic [31:0] npc,
    output logic        valid
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            instr <= '0;
            npc   <= '0;
            valid <= 1'b0;
        end else if (!freeze) begin
            if (flush) begin
                instr <= '0;
                npc   <= '0;
                valid <= 1'b0;
            end else if (wen) begin
                // A wrong-path word is squashed to a zero bubble.
                instr <= fetch_ok ? fetch_instr : '0;
                npc   <= fetch_npc;
                valid <= fetch_ok & ihit;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction-fetch stage: PC, redirect hold and IF/ID capture
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        pc_wen,
    input  logic        if_id_wen,
    input  logic        if_id_flush,
    input  logic        halt,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_npc,
    output logic        if_id_valid,
    output logic        halted
);

    fetch_state_t state;
    word_t        pc;
    word_t        pend_pc;
    word_t        pc_next_seq;
    word_t        target;
    logic         fetch_ok;

    assign pc_next_seq = pc + PC_STEP;
    assign target      = align_word(redirect_pc);
    assign fetch_ok    = (state == FETCH) && !redirect;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= FETCH;
            pc      <= PC_INIT;
            pend_pc <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (halt) begin
                        state <= HALTED;
                    end else if (redirect) begin
                        if (pc_wen) begin
                            pc <= target;
                        end else begin
                            pend_pc <= target;
                            state   <= REDIR_PEND;
                        end
                    end else if (pc_wen) begin
                        pc <= pc_next_seq;
                    end
                end
                REDIR_PEND: begin
                    // A fresh redirect always supersedes the held target.
                    if (halt) begin
                        state <= HALTED;
                    end else if (redirect) begin
                        if (pc_wen) begin
                            pc    <= target;
                            state <= FETCH;
                        end else begin
                            pend_pc <= target;
                        end
                    end else if (pc_wen) begin
                        pc    <= pend_pc;
                        state <= FETCH;
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    assign imemaddr = pc;
    assign imemREN  = (state != HALTED);
    assign halted   = (state == HALTED);

    if_id_latch u_if_id (
        .CLK         (CLK),
        .nRST        (nRST),
        .freeze      (halted),
        .flush       (if_id_flush),
        .wen         (if_id_wen),
        .fetch_ok    (fetch_ok),
        .ihit        (ihit),
        .fetch_instr (imemload),
        .fetch_npc   (pc_next_seq),
        .instr       (if_id_instr),
        .npc         (if_id_npc),
        .valid       (if_id_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage against a behavioural model
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ihit = 1'b0;
    logic [31:0] imemload = '0;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        pc_wen = 1'b0;
    logic        if_id_wen = 1'b0;
    logic        if_id_flush = 1'b0;
    logic        halt = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_npc;
    logic        if_id_valid;
    logic        halted;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model: PC, an optional pending target, a halted flag and the IF/ID contents.
    logic [31:0] m_pc, m_pend_pc, m_instr, m_npc;
    bit          m_pend, m_halted, m_valid;

    fetch_stage #(.PC_INIT(32'h0000_0100)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ihit        (ihit),
        .imemload    (imemload),
        .imemREN     (imemREN),
        .imemaddr    (imemaddr),
        .pc_wen      (pc_wen),
        .if_id_wen   (if_id_wen),
        .if_id_flush (if_id_flush),
        .halt        (halt),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_id_instr (if_id_instr),
        .if_id_npc   (if_id_npc),
        .if_id_valid (if_id_valid),
        .halted      (halted)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h100; m_pend_pc = '0; m_pend = 0; m_halted = 0;
        m_instr = '0; m_npc = '0; m_valid = 0;
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("imemaddr", imemaddr, m_pc);
            chk("imemREN", {31'd0, imemREN}, {31'd0, !m_halted});
            chk("halted", {31'd0, halted}, {31'd0, m_halted});
            chk("if_id_instr", if_id_instr, m_instr);
            chk("if_id_npc", if_id_npc, m_npc);
            chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
        end
    end

    task automatic step(input bit hl, input bit rd, input logic [31:0] rpc, input bit pw,
                        input bit iw, input bit fl, input bit ih, input logic [31:0] ld);
        logic [31:0] tgt;
        bit          on_path;
        halt = hl; redirect = rd; redirect_pc = rpc; pc_wen = pw;
        if_id_wen = iw; if_id_flush = fl; ihit = ih; imemload = ld;
        @(posedge CLK);
        if (nRST && !m_halted) begin
            on_path = !m_pend && !rd;
            if (fl) begin
                m_instr = '0; m_npc = '0; m_valid = 0;
            end else if (iw) begin
                m_npc   = m_pc + 32'd4;
                m_instr = on_path ? ld : 32'd0;
                m_valid = on_path && ih;
            end
            tgt = rpc & 32'hFFFF_FFFC;
            if (hl) begin
                m_halted = 1;
            end else if (rd && pw) begin
                m_pc = tgt; m_pend = 0;
            end else if (rd) begin
                m_pend = 1; m_pend_pc = tgt;
            end else if (pw) begin
                m_pc = m_pend ? m_pend_pc : m_pc + 32'd4;
                m_pend = 0;
            end
        end
        #1;
    endtask

    task automatic run(input logic [31:0] ld);
        step(0, 0, 32'h0, 1, 1, 0, 1, ld);
    endtask

    initial begin
        model_reset();
        chk_en = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst imemaddr", imemaddr, 32'h100);
        chk("rst imemREN", {31'd0, imemREN}, 32'd1);
        chk("rst valid", {31'd0, if_id_valid}, 32'd0);
        nRST = 1'b1;

        // Sequential fetch
        run(32'hAAAA_0001);
        chk("seq addr1", imemaddr, 32'h104);
        chk("seq npc1", if_id_npc, 32'h104);
        run(32'hAAAA_0002);
        chk("seq addr2", imemaddr, 32'h108);
        chk("seq instr2", if_id_instr, 32'hAAAA_0002);
        chk("seq valid2", {31'd0, if_id_valid}, 32'd1);

        // Immediate redirect, unaligned target
        step(0, 1, 32'h203, 1, 1, 0, 1, 32'hBBBB_0000);
        chk("redir addr", imemaddr, 32'h200);
        chk("redir valid", {31'd0, if_id_valid}, 32'd0);
        run(32'hCCCC_0000);

        // Deferred redirect over three stall cycles, newest target wins
        step(0, 1, 32'h400, 0, 1, 0, 1, 32'hD000_0001);
        step(0, 1, 32'h500, 0, 1, 0, 1, 32'hD000_0002);
        step(0, 0, 32'h0,   0, 1, 0, 1, 32'hD000_0003);
        chk("defer hold", imemaddr, 32'h204);
        chk("defer valid", {31'd0, if_id_valid}, 32'd0);
        step(0, 0, 32'h0, 1, 1, 0, 1, 32'hD000_0004);
        chk("defer addr", imemaddr, 32'h500);
        chk("defer valid2", {31'd0, if_id_valid}, 32'd0);
        run(32'hE000_0000);

        // Flush beats write
        step(0, 0, 32'h0, 1, 1, 1, 1, 32'hF000_0000);
        chk("flush instr", if_id_instr, 32'h0);
        chk("flush npc", if_id_npc, 32'h0);

        // Stall without redirect, then write-enable low hold
        step(0, 0, 32'h0, 0, 0, 0, 1, 32'h1234_5678);
        step(0, 0, 32'h0, 1, 1, 0, 0, 32'h1111_2222);

        // Wrap at the top of the address space
        step(0, 1, 32'hFFFF_FFFF, 1, 1, 0, 1, 32'h0);
        chk("wrap pre", imemaddr, 32'hFFFF_FFFC);
        run(32'h7777_0000);
        chk("wrap addr", imemaddr, 32'h0);
        chk("wrap npc", if_id_npc, 32'h0);
        run(32'h7777_0004);

        // Halt while a redirect is pending
        step(0, 1, 32'h600, 0, 1, 0, 1, 32'h0);
        step(1, 0, 32'h0, 0, 1, 0, 1, 32'h0);
        chk("halt halted", {31'd0, halted}, 32'd1);
        chk("halt ren", {31'd0, imemREN}, 32'd0);
        for (int i = 0; i < 10; i++)
            step(1'($urandom_range(0, 1)), 1, $urandom, 1, 1, 1'(i & 1), 1, $urandom);
        chk("halt frozen", imemaddr, 32'h4);

        // Asynchronous reset out of HALTED
        #2;
        nRST = 1'b0;
        model_reset();
        #1;
        chk("rst2 addr", imemaddr, 32'h100);
        chk("rst2 halted", {31'd0, halted}, 32'd0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        run(32'h9999_0000);
        chk("rst2 run", imemaddr, 32'h104);

        @(negedge CLK);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
